// File: rtl/mmio_timer_if.sv
// Data-bus port of the timer: core-side write strobe, address and write data,
// with combinational read data, window hit and the interrupt line coming back.
interface mmio_timer_if;
  logic        WE;
  logic [31:0] A;
  logic [31:0] Wd;
  logic [31:0] Rd;
  logic        hit;
  logic        irq;

  modport master (output WE, A, Wd, input Rd, hit, irq);
  modport slave  (input WE, A, Wd, output Rd, hit, irq);
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled timer with compare/auto-reload/IRQ plus a free-running cycle counter.
// Reads are combinational (0 cycles), writes land on the next rising edge; no backpressure.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  mmio_timer_if.slave bus
);

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd1;
  localparam logic [2:0] OFF_COUNT    = 3'd2;
  localparam logic [2:0] OFF_COMPARE  = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;
  localparam logic [2:0] OFF_CYCLE    = 3'd5;

  logic [2:0]            ctrl;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] pcnt;
  logic [31:0]           count;
  logic [31:0]           compare;
  logic [31:0]           cycle;
  logic                  match;

  logic [2:0]  sel;
  logic        wr;
  logic        wr_ctrl;
  logic        wr_pre;
  logic        wr_count;
  logic        wr_cmp;
  logic        wr_status;
  logic        tick;
  logic        match_set;
  logic [31:0] rd;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^bus.A[1:0];

  assign bus.hit = (bus.A[31:5] == BASE_ADDR[31:5]);
  assign sel     = bus.A[4:2];
  assign wr      = bus.WE & bus.hit;

  assign wr_ctrl   = wr && (sel == OFF_CTRL);
  assign wr_pre    = wr && (sel == OFF_PRESCALE);
  assign wr_count  = wr && (sel == OFF_COUNT);
  assign wr_cmp    = wr && (sel == OFF_COMPARE);
  assign wr_status = wr && (sel == OFF_STATUS);

  assign tick = ctrl[0] && (pcnt == prescale);

  // A bus write to COUNT pre-empts the tick, so no match is evaluated that cycle.
  assign match_set = tick && !wr_count && (count == compare);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (wr_ctrl || wr_pre || !ctrl[0] || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl     <= '0;
      prescale <= '0;
      compare  <= 32'hFFFF_FFFF;
    end else begin
      if (wr_ctrl) ctrl <= bus.Wd[2:0];
      if (wr_pre)  prescale <= bus.Wd[PRESCALE_W-1:0];
      if (wr_cmp)  compare <= bus.Wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (wr_count) begin
      count <= bus.Wd;
    end else if (tick) begin
      count <= (match_set && ctrl[1]) ? 32'd0 : count + 32'd1;
    end
  end

  // Set beats a simultaneous write-one-to-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match <= 1'b0;
    end else if (match_set) begin
      match <= 1'b1;
    end else if (wr_status && bus.Wd[0]) begin
      match <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle <= '0;
    end else begin
      cycle <= cycle + 32'd1;
    end
  end

  always_comb begin
    rd = '0;
    if (bus.hit) begin
      case (sel)
        OFF_CTRL:     rd = {29'd0, ctrl};
        OFF_PRESCALE: rd = 32'(prescale);
        OFF_COUNT:    rd = count;
        OFF_COMPARE:  rd = compare;
        OFF_STATUS:   rd = {31'd0, match};
        OFF_CYCLE:    rd = cycle;
        default:      rd = '0;
      endcase
    end
  end

  assign bus.Rd  = rd;
  assign bus.irq = match & ctrl[2];

endmodule

// File: tb/tb_mmio_timer.sv
// Scoreboard bench for mmio_timer: directed scenarios plus random bus traffic checked
// against a register-level reference model of the timer.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h0000_1000;

  typedef struct {
    logic [31:0] rd;
    logic        hit;
    logic        irq;
    logic [31:0] a;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mmio_timer_if bus ();

  mmio_timer #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t q[$];
  logic chk = 1'b0;
  int   compared = 0;
  int   mism = 0;

  // Reference model state, expressed as the programmer-visible registers.
  logic [2:0]  m_ctrl;
  logic [15:0] m_pre;
  logic [31:0] m_count;
  logic [31:0] m_cmp;
  logic        m_match;
  logic [31:0] m_cycle;
  int          m_since;

  task automatic model_reset();
    m_ctrl = 3'd0; m_pre = 16'd0; m_count = 32'd0; m_cmp = 32'hFFFF_FFFF;
    m_match = 1'b0; m_cycle = 32'd0; m_since = 0;
  endtask

  function automatic logic m_hit(input logic [31:0] a);
    logic [31:0] b;
    b = BASE;
    return a[31:5] == b[31:5];
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!m_hit(a)) return 32'd0;
    case (a[4:2])
      3'd0: return {29'd0, m_ctrl};
      3'd1: return {16'd0, m_pre};
      3'd2: return m_count;
      3'd3: return m_cmp;
      3'd4: return {31'd0, m_match};
      3'd5: return m_cycle;
      default: return 32'd0;
    endcase
  endfunction

  // True when the coming edge is a tick, i.e. PRESCALE+1 enabled clocks have elapsed.
  function automatic logic m_tick_now();
    return m_ctrl[0] && (m_since == int'(m_pre));
  endfunction

  task automatic model_step(input logic we, input logic [31:0] a, input logic [31:0] wd);
    logic        wr, tick, set;
    logic [2:0]  off;
    if (rst) begin
      model_reset();
      return;
    end
    wr   = we && m_hit(a);
    off  = a[4:2];
    tick = m_tick_now();
    set  = tick && !(wr && off == 3'd2) && (m_count == m_cmp);
    if (wr && off == 3'd2)      m_count = wd;
    else if (tick && set && m_ctrl[1]) m_count = 32'd0;
    else if (tick)              m_count = m_count + 32'd1;
    if (set) m_match = 1'b1;
    else if (wr && off == 3'd4 && wd[0]) m_match = 1'b0;
    if ((wr && (off == 3'd0 || off == 3'd1)) || !m_ctrl[0] || tick) m_since = 0;
    else m_since = m_since + 1;
    if (wr && off == 3'd0) m_ctrl = wd[2:0];
    if (wr && off == 3'd1) m_pre = wd[15:0];
    if (wr && off == 3'd3) m_cmp = wd;
    m_cycle = m_cycle + 32'd1;
  endtask

  // One bus cycle: present the access, queue the expected combinational response, clock it.
  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    bus.WE = we; bus.A = a; bus.Wd = wd;
    e.rd  = m_read(a);
    e.hit = m_hit(a);
    e.irq = m_match & m_ctrl[2];
    e.a   = a;
    q.push_back(e);
    chk = 1'b1;
    @(posedge clk);
    model_step(we, a, wd);
    #1;
  endtask

  task automatic wr_reg(input logic [4:0] off, input logic [31:0] d);
    cyc(1'b1, BASE + 32'(off), d);
  endtask

  task automatic rd_reg(input logic [4:0] off);
    cyc(1'b0, BASE + 32'(off), 32'hDEAD_BEEF);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) rd_reg(5'h08);
  endtask

  // Advance until the coming edge is a tick (optionally one that matches); bounded.
  task automatic wait_tick(input string nm, input logic need_match, input int budget);
    int k;
    k = 0;
    while (!(m_tick_now() && (!need_match || m_count == m_cmp)) && k < budget) begin
      rd_reg(5'h08);
      k++;
    end
    if (k >= budget) begin
      mism++;
      $display("FAIL %s: event not reached within %0d cycles", nm, budget);
    end
  endtask

  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] act, input logic [31:0] e);
    compared++;
    if (act !== e) begin
      mism++;
      $display("FAIL %s @A=%h: got %h, expected %h", nm, a, act, e);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      if (q.size() == 0) begin
        mism++;
        $display("FAIL scoreboard: DUT cycle with no expected entry");
      end else begin
        exp_t e;
        e = q.pop_front();
        cmp("rd", e.a, bus.Rd, e.rd);
        cmp("hit", e.a, {31'd0, bus.hit}, {31'd0, e.hit});
        cmp("irq", e.a, {31'd0, bus.irq}, {31'd0, e.irq});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, a;
    int r;
    rst = 1'b1;
    bus.WE = 1'b0; bus.A = 32'd0; bus.Wd = 32'd0;
    model_reset();
    @(posedge clk); #1;
    for (int o = 0; o < 32; o += 4) rd_reg(5'(o));
    rst = 1'b0;
    rd_reg(5'h14);
    rd_reg(5'h14);

    // Basic count, then a slower prescale.
    wr_reg(5'h04, 32'd0);
    wr_reg(5'h00, 32'd1);
    idle(10);
    wr_reg(5'h08, 32'd0);
    wr_reg(5'h04, 32'hABCD_0003);
    idle(12);
    rd_reg(5'h04);

    // Compare with auto-reload, W1C colliding with a match, then a plain clear.
    wr_reg(5'h04, 32'd0);
    wr_reg(5'h0C, 32'd5);
    wr_reg(5'h08, 32'd0);
    wr_reg(5'h00, 32'hFFFF_FFFF);
    rd_reg(5'h00);
    idle(14);
    wait_tick("w1c_collision", 1'b1, 40);
    wr_reg(5'h10, 32'd1);
    rd_reg(5'h10);
    wr_reg(5'h10, 32'd1);
    rd_reg(5'h10);

    // Wrap without reload.
    wr_reg(5'h00, 32'd1);
    wr_reg(5'h0C, 32'd3);
    wr_reg(5'h08, 32'hFFFF_FFFE);
    idle(8);

    // Bus write to COUNT on a tick edge.
    wr_reg(5'h04, 32'd3);
    idle(2);
    wait_tick("count_collision", 1'b0, 20);
    wr_reg(5'h08, 32'd100);
    rd_reg(5'h08);

    // Decode window.
    cyc(1'b0, 32'h0000_2008, 32'd0);
    cyc(1'b1, 32'h0000_2008, 32'd123);
    cyc(1'b0, 32'h0000_100A, 32'd0);
    wr_reg(5'h14, 32'd0);
    wr_reg(5'h18, 32'h1234_5678);
    rd_reg(5'h18);
    rd_reg(5'h1C);

    // Asynchronous reset in the middle of a cycle while counting.
    #2 rst = 1'b1;
    model_reset();
    for (int o = 0; o < 32; o += 4) rd_reg(5'(o));
    rst = 1'b0;
    rd_reg(5'h14);
    rd_reg(5'h14);

    // Random traffic with values kept small so matches and wraps happen often.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      a = BASE + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 19) == 0) a = $urandom;
      d = $urandom;
      case (a[4:2])
        3'd1: d[15:0] = 16'($urandom_range(0, 3));
        3'd2: d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFD : 32'($urandom_range(0, 12));
        3'd3: d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 12));
        default: ;
      endcase
      if (a[4:2] == 3'd0 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      cyc(r < 3, a, d);
    end

    chk = 1'b0;
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      mism++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
